// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit: access-op encoding, FSM states
// and small decode helpers used by the top and the lane datapath.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(lsu_op_e op);
        return op inside {LW, LH, LHU, LB, LBU};
    endfunction

    function automatic logic op_is_legal(lsu_op_e op);
        case (op)
            LW, LH, LHU, LB, LBU, SW, SH, SB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(lsu_op_e op, logic [1:0] off);
        if (op inside {LH, LHU, SH}) return off[0];
        if (op inside {LW, SW})      return off != 2'b00;
        return 1'b0;
    endfunction

    // Clears the low offset bits a misaligned halfword/word access would use.
    function automatic logic [1:0] op_align_off(lsu_op_e op, logic [1:0] off);
        if (op inside {LH, LHU, SH}) return {off[1], 1'b0};
        if (op inside {LW, SW})      return 2'b00;
        return off;
    endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// The LSU uses the slave modport; the requester/memory side uses master.
interface mips_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        signal_mem_read;
    logic        signal_mem_write;
    logic [31:0] read_data;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               address, write_data, signal_mem_read, signal_mem_write
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               address, write_data, signal_mem_read, signal_mem_write
    );
endinterface

// File: rtl/mips_lsu_lane.sv
// Combinational byte-lane datapath: extracts/extends load data from a memory
// word and merges store data into it (little-endian lanes).
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  lsu_op_e     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (op_i)
            LW:      load_o = word_i;
            LH:      load_o = {{16{half_sel[15]}}, half_sel};
            LHU:     load_o = {16'h0, half_sel};
            LB:      load_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_o = {24'h0, byte_sel};
            default: load_o = 32'h0;
        endcase

        // Untouched lanes keep the word read back during the RMW.
        store_o = word_i;
        case (op_i)
            SW: store_o = wdata_i;
            SH: begin
                if (off_i[1]) store_o[31:16] = wdata_i[15:0];
                else          store_o[15:0]  = wdata_i[15:0];
            end
            SB:      store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            default: store_o = word_i;
        endcase
    end
endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: one request at a time, sub-word stores via read-modify-write.
// Define MIPS_LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_WORD_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_load_store_unit_if.slave  bus
);
    localparam int AW = MEM_WORD_BITS + 2;

    lsu_state_e     state_q, state_d;
    lsu_op_e        op_q, op_d, req_op;
    logic [AW-1:0]  addr_q, addr_d, req_addr;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    word_q, word_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           out_of_range, req_fault;
    logic [31:0]    lane_word, load_data, store_word;
    logic           req_ready, mem_rd, mem_wr;
    logic [31:0]    wr_data;

    assign req_op       = lsu_op_e'(bus.req_op);
    assign out_of_range = (bus.req_addr >> AW) != 32'd0;

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    assign req_fault = out_of_range || !op_is_legal(req_op)
                    || op_misaligned(req_op, bus.req_addr[1:0]);
    assign req_addr  = bus.req_addr[AW-1:0];
`else
    assign req_fault = out_of_range || !op_is_legal(req_op);
    assign req_addr  = {bus.req_addr[AW-1:2], op_align_off(req_op, bus.req_addr[1:0])};
`endif

    // In READ the lane works on the live memory word; in WRITE on the captured one.
    assign lane_word = (state_q == READ) ? bus.read_data : word_q;

    mips_lsu_lane u_lane (
        .op_i    (op_q),
        .off_i   (addr_q[1:0]),
        .word_i  (lane_word),
        .wdata_i (wdata_q),
        .load_o  (load_data),
        .store_o (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        wr_data   = 32'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (req_fault) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_op == SW) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_rd = 1'b1;
                if (op_is_load(op_q)) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else begin
                    word_d  = bus.read_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_wr  = 1'b1;
                wr_data = store_word;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready        = req_ready;
    assign bus.resp_valid       = (state_q == RESP);
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_err         = err_q;
    assign bus.address          = 32'(addr_q[AW-1:2]);
    assign bus.write_data       = wr_data;
    assign bus.signal_mem_read  = mem_rd;
    assign bus.signal_mem_write = mem_wr;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit: directed scenarios then random
// requests, checked against a word-array reference model of the memory.
module tb_mips_load_store_unit;
  import mips_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_load_store_unit_if bus();

  mips_load_store_unit #(.MEM_WORD_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int vectors = 0;
  int miscompares = 0;

  assign bus.read_data = mem[bus.address[7:0]];
  always @(posedge clk) if (bus.signal_mem_write) mem[bus.address[7:0]] <= bus.write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: expected response, latency and strobe counts from the access rules.
  task automatic model(input lsu_op_e op, input logic [31:0] a_in, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int nrd, output int nwr);
    logic [31:0] a, w, v, mask;
    int idx, sh;
    bit half, word, mis;
    a    = a_in;
    half = op inside {LH, LHU, SH};
    word = op inside {LW, SW};
    mis  = (half && a[0]) || (word && a[1:0] != 2'b00);
    err  = (a >= 32'd1024);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    err = err || mis;
`else
    if (mis) a = half ? (a & ~32'd1) : (a & ~32'd3);
`endif
    rd = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (err) return;
    idx = int'(a / 4);
    sh  = 8 * int'(a % 4);
    w   = ref_mem[idx];
    case (op)
      LW: rd = w;
      LB, LBU: begin
        v  = (w >> sh) & 32'hFF;
        rd = (op == LB && v >= 32'd128) ? v - 32'd256 : v;
      end
      LH, LHU: begin
        v  = (w >> sh) & 32'hFFFF;
        rd = (op == LH && v >= 32'd32768) ? v - 32'd65536 : v;
      end
      SW: ref_mem[idx] = wd;
      SB: begin
        mask = 32'hFF << sh;
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << sh);
      end
      SH: begin
        mask = 32'hFFFF << sh;
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: ;
    endcase
    lat = (op inside {SH, SB}) ? 3 : 2;
    nrd = (op == SW) ? 0 : 1;
    nwr = op_is_load(op) ? 0 : 1;
  endtask

  task automatic xact(input lsu_op_e op, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd);
    logic [31:0] erd;
    logic eerr;
    int elat, enrd, enwr, cyc, nrd, nwr;
    model(op, a, wd, erd, eerr, elat, enrd, enwr);
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    cyc = 0; nrd = 0; nwr = 0;
    while (cyc < 10) begin
      @(negedge clk); cyc++;
      if (bus.resp_valid) break;
      chk("strobe_exclusive", 32'(bus.signal_mem_read & bus.signal_mem_write), 32'd0);
      nrd += int'(bus.signal_mem_read);
      nwr += int'(bus.signal_mem_write);
    end
    chk("resp_latency", 32'(cyc), 32'(elat));
    chk("read_strobes", 32'(nrd), 32'(enrd));
    chk("write_strobes", 32'(nwr), 32'(enwr));
    chk("resp_rdata", bus.resp_rdata, erd);
    chk("resp_err", 32'(bus.resp_err), 32'(eerr));
    rd = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, erd);
      chk("hold_err", 32'(bus.resp_err), 32'(eerr));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_strobes", 32'({bus.signal_mem_read, bus.signal_mem_write}), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;

    #12;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_strobes", 32'({bus.signal_mem_read, bus.signal_mem_write}), 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Word store/load round trip.
    xact(SW, 32'h10, 32'hDEADBEEF, 0, r);
    chk("sw_mem_idx4", mem[4], 32'hDEADBEEF);
    xact(LW, 32'h10, 32'h0, 0, r);
    chk("lw_deadbeef", r, 32'hDEADBEEF);

    // Byte merge and sign/zero extension.
    xact(SW, 32'h20, 32'h11223344, 0, r);
    xact(SB, 32'h21, 32'h000000AA, 0, r);
    chk("sb_merge_mem", mem[8], 32'h1122AA44);
    xact(LB, 32'h21, 32'h0, 0, r);
    chk("lb_sext", r, 32'hFFFFFFAA);
    xact(LBU, 32'h21, 32'h0, 0, r);
    chk("lbu_zext", r, 32'h000000AA);

    // Upper halfword extension.
    xact(SW, 32'h20, 32'h80010000, 0, r);
    xact(LH, 32'h22, 32'h0, 0, r);
    chk("lh_sext", r, 32'hFFFF8001);
    xact(LHU, 32'h22, 32'h0, 0, r);
    chk("lhu_zext", r, 32'h00008001);
    xact(SH, 32'h22, 32'h0000BEEF, 0, r);
    chk("sh_merge_mem", mem[8], 32'hBEEF0000);

    // Out of range, then response back-pressure.
    xact(LW, 32'h00000400, 32'h0, 0, r);
    xact(SW, 32'h80000010, 32'h12345678, 2, r);
    xact(LW, 32'h10, 32'h0, 5, r);

    // Reset in the middle of a store must suppress the write.
    xact(SW, 32'h30, 32'hCAFEF00D, 0, r);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h30; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_write", 32'(bus.signal_mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 32'(bus.signal_mem_write), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_mem_kept", mem[12], 32'hCAFEF00D);
    xact(LW, 32'h31, 32'h0, 0, r);

    // Random mix, mostly in a small window so loads hit earlier stores.
    for (int i = 0; i < 120; i++) begin
      lsu_op_e op;
      logic [31:0] a;
      op = lsu_op_e'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
      xact(op, a, $urandom, int'($urandom_range(0, 2)), r);
    end

    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_load_store_unit.md
MIPS_LOAD_STORE_UNIT -- requirements
Module: mips_load_store_unit

Interface
REQ-001 Parameter MEM_WORD_BITS, default 8, word-index width; 2**MEM_WORD_BITS words are addressable.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_op  input  3  access type: LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 resp_valid  output  1  response present.
REQ-010 resp_ready  input  1  consumer accepts the response.
REQ-011 resp_rdata  output  32  load result, extended per op; 0 for stores.
REQ-012 resp_err  output  1  access faulted; no memory write occurred.
REQ-013 address  output  32  word index to data memory (zero-extended addr[MEM_WORD_BITS+1:2]).
REQ-014 write_data  output  32  word to data memory.
REQ-015 signal_mem_read  output  1  memory read strobe.
REQ-016 signal_mem_write  output  1  memory write strobe; memory writes on posedge clk.
REQ-017 read_data  input  32  combinational word from data memory.

Function
REQ-018 FSM states: IDLE, READ, WRITE, RESP.
REQ-019 req_ready is 1 only in IDLE; a request is accepted on a cycle with req_valid and req_ready both 1; op, addr and wdata are registered at acceptance.
REQ-020 Load: IDLE -> READ (signal_mem_read=1, read_data captured) -> RESP; resp_valid rises 2 cycles after acceptance.
REQ-021 SW: IDLE -> WRITE (signal_mem_write=1, write_data=wdata) -> RESP.
REQ-022 SH/SB (read-modify-write): IDLE -> READ -> WRITE -> RESP; WRITE merges the new lane(s) into the captured word and leaves the other bytes unchanged.
REQ-023 Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; halfword addr[1]=0 selects bits 15:0.
REQ-024 LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-025 Out of range (addr[31:MEM_WORD_BITS+2] != 0): IDLE -> RESP directly, resp_err=1, resp_rdata=0, both strobes 0.
REQ-026 RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready=1, then goes to IDLE; a new request can be accepted no earlier than the next cycle.
REQ-027 signal_mem_read and signal_mem_write are never 1 in the same cycle and are 0 outside READ/WRITE.
REQ-028 An undefined req_op sets resp_err=1 with no memory access, handled the same as REQ-025.

Reset
REQ-029 rst_n=0 forces IDLE immediately; outputs resp_valid=0, resp_err=0, resp_rdata=0, strobes=0, address=0, write_data=0, req_ready=1 after release.
REQ-030 Reset asserted during READ or WRITE aborts the access; signal_mem_write drops asynchronously, so no write occurs at the next edge.

Configuration
REQ-031 Macro MIPS_LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> RESP with resp_err=1 and no access. Undefined: offending low address bits are forced to 0 and the access proceeds normally with resp_err=0.

Structure
REQ-032 Package mips_lsu_pkg holds the req_op encoding (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7) and the FSM state enum.
REQ-033 Combinational sub-module mips_lsu_lane performs lane extract/extend and store merge; the FSM and registers stay in the top module.

Verification
REQ-034 SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> write at index 4; load resp_rdata=0xDEADBEEF 2 cycles after acceptance.
REQ-035 Word 0x11223344 at 0x20; SB addr=0x21, wdata=0xAA -> word becomes 0x1122AA44; LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA.
REQ-036 LH 0x22 on 0x8001_0000 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-037 LW addr=0x0000_0400 (MEM_WORD_BITS=8) -> resp_err=1, no strobes, resp 1 cycle after acceptance.
REQ-038 With resp_ready=0 for 5 cycles -> resp_valid and data held stable, req_ready=0 throughout.
REQ-039 rst_n low during WRITE of SW 0x30 -> no write; word at 0x30 keeps its old value. LW 0x31 -> resp_err=1 when MIPS_LSU_MISALIGN_TRAP_EN is defined, else reads the word at 0x30.
